// File: rtl/leaf_sched_pkg.sv
// Shared constants, encodings and the routing helper for the leaf crossbar scheduler.
package leaf_sched_pkg;

  localparam logic [2:0] P_GPU = 3'd0;
  localparam logic [2:0] P_SP1 = 3'd1;
  localparam logic [2:0] P_SP2 = 3'd2;
  localparam logic [2:0] P_SP3 = 3'd3;
  localparam logic [2:0] P_SP4 = 3'd4;

  localparam logic [2:0] NO_GRANT = 3'd7;

  localparam logic [1:0] DIR_IDLE    = 2'b00;
  localparam logic [1:0] DIR_UP      = 2'b01;
  localparam logic [1:0] DIR_DOWN    = 2'b10;
  localparam logic [1:0] DIR_TRANSIT = 2'b11;

  typedef enum logic {S_IDLE, S_XFER} state_t;

  // Local group lands on the GPU port; foreign groups pick a spine by the low address bits.
  function automatic logic [2:0] route_port(input logic [5:0] dest, input logic [3:0] group_id);
    logic [2:0] port;
    if (dest[5:2] == group_id) begin
      port = P_GPU;
    end else begin
      case (dest[1:0])
        2'd0:    port = P_SP1;
        2'd1:    port = P_SP2;
        2'd2:    port = P_SP3;
        default: port = P_SP4;
      endcase
    end
    return port;
  endfunction

endpackage

// File: rtl/leaf_crossbar_scheduler_rr_pick5.sv
// Combinational 5-way round-robin picker: first requester at or after ptr, wrapping at 5.
module rr_pick5 (
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic       valid,
  output logic [2:0] idx
);

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    logic [3:0] pos;
    valid = 1'b0;
    idx   = 3'd0;
    pos   = 4'd0;
    for (int k = 4; k >= 0; k--) begin
      pos = {1'b0, ptr} + 4'(k);
      if (pos >= 4'd5) pos = pos - 4'd5;
      if (req[pos[2:0]]) begin
        valid = 1'b1;
        idx   = pos[2:0];
      end
    end
  end

endmodule

// File: rtl/leaf_crossbar_scheduler.sv
// Leaf-router crossbar scheduler: round-robin packet grants, destination routing and stall watchdog.
// Defining LEAF_SCHED_STATS_EN adds saturating per-source packet and abort counters.
module leaf_crossbar_scheduler
  import leaf_sched_pkg::*;
#(
  parameter logic [3:0] GROUP_ID    = 4'b0111,
  parameter int         NSRC        = 5,
  parameter int         LEN_W       = 4,
  parameter int         TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arb_enable,
  input  logic [NSRC-1:0]       src_req,
  input  logic [6*NSRC-1:0]     src_dest,
  input  logic [LEN_W*NSRC-1:0] src_len,
  input  logic [NSRC-1:0]       src_beat,
  input  logic [NSRC-1:0]       dst_ready,
  output logic [NSRC-1:0]       grant_oh,
  output logic [2:0]            grant_id,
  output logic [2:0]            out_sel,
  output logic                  out_en,
  output logic                  busy,
  output logic [1:0]            direction,
  output logic                  timeout_err
`ifdef LEAF_SCHED_STATS_EN
  ,
  output logic [16*NSRC-1:0]    pkt_cnt,
  output logic [15:0]           abort_cnt
`endif
);

  localparam int                WD_W     = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0]   WD_ONE   = WD_W'(1);
  localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [LEN_W:0]    ONE_LEN  = (LEN_W+1)'(1);
  localparam logic [NSRC-1:0]   ONE_HOT0 = NSRC'(1);

  state_t            state;
  logic [2:0]        rr_ptr;
  logic [LEN_W:0]    len_q;
  logic [LEN_W:0]    beat_cnt;
  logic [WD_W-1:0]   wd_cnt;

  logic              pick_valid;
  logic [2:0]        pick_idx;
  logic [5:0]        pick_dest;
  logic [LEN_W-1:0]  pick_len_raw;
  logic [LEN_W:0]    pick_len;
  logic [2:0]        pick_sel;
  logic [1:0]        pick_dir;
  logic [NSRC-1:0]   sel_oh;
  logic [2:0]        next_ptr;
  logic              beat;
  logic              last_beat;
  logic              wd_expire;

  rr_pick5 u_pick (
    .req   (src_req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_dest    = '0;
    pick_len_raw = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (pick_idx == 3'(i)) begin
        pick_dest    = src_dest[6*i +: 6];
        pick_len_raw = src_len[LEN_W*i +: LEN_W];
      end
    end
  end

  assign pick_len = (pick_len_raw == '0) ? ONE_LEN : {1'b0, pick_len_raw};
  assign pick_sel = route_port(pick_dest, GROUP_ID);
  assign pick_dir = (pick_sel == P_GPU) ? DIR_DOWN :
                    (pick_idx == P_GPU) ? DIR_UP : DIR_TRANSIT;

  // out_en is low only for a hairpin, which drains on src_beat alone.
  assign sel_oh    = ONE_HOT0 << out_sel;
  assign beat      = (state == S_XFER) && (|(src_beat & grant_oh))
                     && (!out_en || (|(dst_ready & sel_oh)));
  assign last_beat = beat && (beat_cnt == len_q - ONE_LEN);
  assign wd_expire = (state == S_XFER) && !beat && (wd_cnt == WD_MAX);
  assign next_ptr  = (grant_id == P_SP4) ? P_GPU : grant_id + 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      grant_oh    <= '0;
      grant_id    <= NO_GRANT;
      out_sel     <= P_GPU;
      out_en      <= 1'b0;
      busy        <= 1'b0;
      direction   <= DIR_IDLE;
      timeout_err <= 1'b0;
      rr_ptr      <= P_GPU;
      len_q       <= '0;
      beat_cnt    <= '0;
      wd_cnt      <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arb_enable && pick_valid) begin
            state     <= S_XFER;
            grant_id  <= pick_idx;
            grant_oh  <= ONE_HOT0 << pick_idx;
            out_sel   <= pick_sel;
            out_en    <= (pick_sel != pick_idx);
            busy      <= 1'b1;
            direction <= pick_dir;
            len_q     <= pick_len;
            beat_cnt  <= '0;
            wd_cnt    <= '0;
          end
        end
        S_XFER: begin
          if (last_beat || wd_expire) begin
            state       <= S_IDLE;
            grant_id    <= NO_GRANT;
            grant_oh    <= '0;
            out_sel     <= P_GPU;
            out_en      <= 1'b0;
            busy        <= 1'b0;
            direction   <= DIR_IDLE;
            rr_ptr      <= next_ptr;
            timeout_err <= wd_expire;
          end else if (beat) begin
            beat_cnt <= beat_cnt + ONE_LEN;
            wd_cnt   <= '0;
          end else begin
            wd_cnt <= wd_cnt + WD_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LEAF_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_cnt   <= '0;
      abort_cnt <= '0;
    end else begin
      if (wd_expire && abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 16'd1;
      for (int i = 0; i < NSRC; i++) begin
        if (last_beat && grant_oh[i] && pkt_cnt[16*i +: 16] != 16'hFFFF)
          pkt_cnt[16*i +: 16] <= pkt_cnt[16*i +: 16] + 16'd1;
      end
    end
  end
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_leaf_crossbar_scheduler.sv
// Scoreboard bench for leaf_crossbar_scheduler: directed cases plus randomized packet mixes.
// Also covers the LEAF_SCHED_STATS_EN counters when that macro is defined.
module tb_leaf_crossbar_scheduler;

  typedef struct {
    int gid;
    int sel;
    bit en;
    int dir;
    int len;
    bit tmo;
    int exp_cycle;
    int exp_gap;
    int exp_busy;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        arb_enable;
  logic [4:0]  src_req;
  logic [29:0] src_dest;
  logic [19:0] src_len;
  logic [4:0]  src_beat;
  logic [4:0]  dst_ready;
  logic [4:0]  grant_oh;
  logic [2:0]  grant_id;
  logic [2:0]  out_sel;
  logic        out_en;
  logic        busy;
  logic [1:0]  direction;
  logic        timeout_err;
`ifdef LEAF_SCHED_STATS_EN
  logic [79:0] pkt_cnt;
  logic [15:0] abort_cnt;
  int          done_model[5];
  int          abort_model;
`endif

  int          checks;
  int          errors;
  int          cyc;
  int          grants_seen;
  int          last_beat_cyc;
  int          model_ptr;
  exp_t        exp_q[$];
  logic [5:0]  dest_a[5];
  logic [3:0]  len_a[5];
  logic [4:0]  held_ready;
  bit          rand_beats;

  leaf_crossbar_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .arb_enable  (arb_enable),
    .src_req     (src_req),
    .src_dest    (src_dest),
    .src_len     (src_len),
    .src_beat    (src_beat),
    .dst_ready   (dst_ready),
    .grant_oh    (grant_oh),
    .grant_id    (grant_id),
    .out_sel     (out_sel),
    .out_en      (out_en),
    .busy        (busy),
    .direction   (direction),
    .timeout_err (timeout_err)
`ifdef LEAF_SCHED_STATS_EN
    ,
    .pkt_cnt     (pkt_cnt),
    .abort_cnt   (abort_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Beat/ready driver: either follows the held pattern or randomizes at ~75% density.
  always @(posedge clk) begin
    #2;
    if (rand_beats) begin
      src_beat  = 5'($urandom) | 5'($urandom);
      dst_ready = 5'($urandom) | 5'($urandom);
    end else begin
      src_beat  = 5'b11111;
      dst_ready = held_ready;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_grant_oh"}, int'(grant_oh), 0);
    checkOutput({tag, "_grant_id"}, int'(grant_id), 7);
    checkOutput({tag, "_out_sel"}, int'(out_sel), 0);
    checkOutput({tag, "_out_en"}, int'(out_en), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_direction"}, int'(direction), 0);
    checkOutput({tag, "_timeout_err"}, int'(timeout_err), 0);
  endtask

  function automatic int route(input logic [5:0] d);
    if (d[5:2] == 4'b0111) return 0;
    return 1 + int'(d[1:0]);
  endfunction

  function automatic int dir_of(input int s, input int p);
    if (p == 0) return 2;
    if (s == 0) return 1;
    return 3;
  endfunction

  function automatic int pick(input logic [4:0] m);
    for (int k = 0; k < 5; k++) begin
      if (m[(model_ptr + k) % 5]) return (model_ptr + k) % 5;
    end
    return -1;
  endfunction

  function automatic exp_t make_exp(input int w, input int ecyc, input int egap,
                                    input int ebusy, input bit tmo);
    exp_t e;
    e.gid       = w;
    e.sel       = route(dest_a[w]);
    e.en        = (e.sel != w);
    e.dir       = dir_of(w, e.sel);
    e.len       = (len_a[w] == 4'd0) ? 1 : int'(len_a[w]);
    e.tmo       = tmo;
    e.exp_cycle = ecyc;
    e.exp_gap   = egap;
    e.exp_busy  = ebusy;
    return e;
  endfunction

  task automatic packInputs();
    for (int i = 0; i < 5; i++) begin
      src_dest[6*i +: 6] = dest_a[i];
      src_len[4*i +: 4]  = len_a[i];
    end
  endtask

  // One scenario: hold a request mask, expect n grants in round-robin order, then
  // drop arb_enable and confirm the still-pending requests are left alone.
  task automatic applyStimulus(input logic [4:0] mask, input int n, input bit rnd,
                               input logic [4:0] ready0, input int stall,
                               input int busy0, input bit tmo, input bit chk_gap);
    int d;
    int w;
    int target;
    int t;
    @(posedge clk);
    #1;
    d = cyc;
    for (int k = 0; k < n; k++) begin
      w = pick(mask);
      exp_q.push_back(make_exp(w, (k == 0) ? d + 1 : -1, (k > 0 && chk_gap) ? 2 : -1,
                               (k == 0) ? busy0 : -1, tmo));
      model_ptr = (w + 1) % 5;
    end
    target = grants_seen + n;
    packInputs();
    rand_beats = rnd;
    held_ready = ready0;
    src_req    = mask;
    arb_enable = 1'b1;
    if (stall > 0) begin
      repeat (1 + stall) @(posedge clk);
      #1;
      held_ready = 5'b11111;
    end
    t = 0;
    while (grants_seen < target && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (grants_seen < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_wait: saw %0d grants, expected %0d", grants_seen, target);
    end
    arb_enable = 1'b0;
    t = 0;
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL release_wait: busy still %0d, expected 0", busy);
    end
    repeat (5) @(negedge clk);
    checkOutput("leftover_expect", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    src_req    = 5'b00000;
    rand_beats = 1'b0;
    held_ready = 5'b11111;
    arb_enable = 1'b1;
  endtask

`ifdef LEAF_SCHED_STATS_EN
  task automatic checkStats();
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("pkt_cnt%0d", i), int'(pkt_cnt[16*i +: 16]), done_model[i]);
    checkOutput("abort_cnt", int'(abort_cnt), abort_model);
  endtask
`endif

  // Monitor: pops the expected grant when busy rises, counts beats from the
  // spec's beat rule, and settles each packet when busy falls.
  initial begin : monitor
    exp_t cur;
    bit   cur_valid;
    bit   prev_busy;
    int   beats;
    int   busy_cyc;
    cur_valid = 1'b0;
    prev_busy = 1'b0;
    beats     = 0;
    busy_cyc  = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cur_valid = 1'b0;
        prev_busy = 1'b0;
`ifdef LEAF_SCHED_STATS_EN
        for (int i = 0; i < 5; i++) done_model[i] = 0;
        abort_model = 0;
`endif
      end else begin
        if (busy && !prev_busy) begin
          grants_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_grant: got grant_id %0d, expected no grant", grant_id);
            cur_valid = 1'b0;
          end else begin
            cur = exp_q.pop_front();
            cur_valid = 1'b1;
            checkOutput("grant_id", int'(grant_id), cur.gid);
            checkOutput("grant_oh", int'(grant_oh), 1 << cur.gid);
            checkOutput("out_sel", int'(out_sel), cur.sel);
            checkOutput("out_en", int'(out_en), int'(cur.en));
            checkOutput("direction", int'(direction), cur.dir);
            if (cur.exp_cycle >= 0) checkOutput("grant_latency", cyc, cur.exp_cycle);
            if (cur.exp_gap >= 0) checkOutput("grant_gap", cyc - last_beat_cyc, cur.exp_gap);
            beats    = 0;
            busy_cyc = 0;
          end
        end
        if (busy && cur_valid) begin
          busy_cyc++;
          if (src_beat[cur.gid] && (cur.sel == cur.gid || dst_ready[cur.sel])) begin
            beats++;
            if (beats == cur.len) last_beat_cyc = cyc;
          end
        end
        if (!busy && prev_busy) begin
          if (cur_valid) begin
            checkOutput("packet_beats", beats, cur.tmo ? 0 : cur.len);
            if (cur.exp_busy >= 0) checkOutput("busy_cycles", busy_cyc, cur.exp_busy);
            checkOutput("timeout_pulse", int'(timeout_err), int'(cur.tmo));
            checkOutput("idle_outputs", int'({grant_oh, grant_id, out_sel, out_en, direction}),
                        int'({5'b0, 3'd7, 3'd0, 1'b0, 2'b00}));
`ifdef LEAF_SCHED_STATS_EN
            if (cur.tmo) abort_model++;
            else done_model[cur.gid]++;
`endif
            cur_valid = 1'b0;
          end
        end else if (timeout_err) begin
          checks++;
          errors++;
          $display("[TB] FAIL spurious_timeout: got timeout_err 1, expected 0");
        end
        prev_busy = busy;
      end
    end
  end

  initial begin : stimulus
    logic [4:0] m;
    int         d;
    checks        = 0;
    errors        = 0;
    cyc           = 0;
    grants_seen   = 0;
    last_beat_cyc = 0;
    model_ptr     = 0;
    reset         = 1'b0;
    arb_enable    = 1'b0;
    src_req       = 5'b00000;
    src_dest      = '0;
    src_len       = '0;
    held_ready    = 5'b11111;
    rand_beats    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dest_a[i] = 6'b011100;
      len_a[i]  = 4'd1;
    end
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    reset      = 1'b1;
    arb_enable = 1'b1;
    $display("[TB] reset released, starting directed cases");

    // GPU to spine3, three beats.
    dest_a[0] = 6'b000110;
    len_a[0]  = 4'd3;
    applyStimulus(5'b00001, 1, 1'b0, 5'b11111, 0, 3, 1'b0, 1'b0);

    // Spine2 into the local group, GPU port stalled for five cycles.
    dest_a[2] = 6'b011101;
    len_a[2]  = 4'd2;
    applyStimulus(5'b00100, 1, 1'b0, 5'b11110, 5, 7, 1'b0, 1'b0);

    // GPU with its spine port stuck: watchdog abort after 64 cycles.
    dest_a[0] = 6'b000001;
    len_a[0]  = 4'd4;
    applyStimulus(5'b00001, 1, 1'b0, 5'b00000, 0, 64, 1'b1, 1'b0);
`ifdef LEAF_SCHED_STATS_EN
    checkStats();
`endif

    // After the abort the pointer sits past the GPU, so spine1 wins over the GPU.
    dest_a[0] = 6'b000000;
    len_a[0]  = 4'd1;
    dest_a[1] = 6'b011100;
    len_a[1]  = 4'd1;
    applyStimulus(5'b00011, 1, 1'b0, 5'b11111, 0, 1, 1'b0, 1'b0);

    // Spine1 hairpin drains with every dst_ready low.
    dest_a[1] = 6'b001100;
    len_a[1]  = 4'd4;
    applyStimulus(5'b00010, 1, 1'b0, 5'b00000, 0, 4, 1'b0, 1'b0);

    // Reset in the middle of a long packet clears the outputs at once.
    dest_a[3] = 6'b000000;
    len_a[3]  = 4'd15;
    @(posedge clk);
    #1;
    d = cyc;
    exp_q.push_back(make_exp(pick(5'b01000), d + 1, -1, -1, 1'b0));
    packInputs();
    held_ready = 5'b00000;
    src_req    = 5'b01000;
    arb_enable = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkResetOutputs("midreset");
    @(negedge clk);
    @(posedge clk);
    #1;
    reset      = 1'b1;
    src_req    = 5'b00000;
    held_ready = 5'b11111;
    model_ptr  = 0;
    exp_q.delete();

    // All five requesting with single-flit packets: 0,1,2,3,4,0 two cycles apart.
    for (int i = 0; i < 5; i++) begin
      dest_a[i] = (i == 0) ? 6'b000000 : 6'b011100;
      len_a[i]  = 4'd1;
    end
    applyStimulus(5'b11111, 6, 1'b0, 5'b11111, 0, 1, 1'b0, 1'b1);

    $display("[TB] directed cases done, starting random mixes");
    for (int s = 0; s < 12; s++) begin
      for (int i = 0; i < 5; i++) begin
        dest_a[i] = 6'($urandom);
        if ($urandom_range(0, 2) == 0) dest_a[i][5:2] = 4'b0111;
        len_a[i] = 4'($urandom);
      end
      m = 5'($urandom_range(1, 31));
      applyStimulus(m, int'($urandom_range(1, 4)), 1'b1, 5'b11111, 0, -1, 1'b0, 1'b0);
    end
`ifdef LEAF_SCHED_STATS_EN
    checkStats();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
